// File: rtl/branch_flow_ctrl_if.sv
// Handshake bundle between decode/ALU, fetch and the program-flow controller.
// br_taken_cnt/br_nt_cnt carry live counts only when BRANCH_STATS_EN is defined.
interface branch_flow_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              stall;
  logic              instr_valid;
  logic [1:0]        br_op;
  logic [2:0]        cond;
  logic [8:0]        br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [2:0]        flag_we;
  logic [2:0]        alu_nvz;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic [2:0]        nvz;
  logic              halted;
  logic              taken;
  logic [15:0]       br_taken_cnt;
  logic [15:0]       br_nt_cnt;

  modport master (
    output stall, instr_valid, br_op, cond, br_off, br_tgt, flag_we, alu_nvz,
    input  pc, flush, nvz, halted, taken, br_taken_cnt, br_nt_cnt
  );

  modport slave (
    input  stall, instr_valid, br_op, cond, br_off, br_tgt, flag_we, alu_nvz,
    output pc, flush, nvz, halted, taken, br_taken_cnt, br_nt_cnt
  );
endinterface

// File: rtl/branch_flow_ctrl.sv
// Program-flow controller: NVZ flags, branch evaluation, fetch PC, flush and halt.
// Optional macro BRANCH_STATS_EN enables saturating taken/not-taken branch counters.
//
// state    | meaning
// ST_RUN   | normal sequencing, instructions may be active
// ST_FLUSH | one unstalled cycle squashing the wrong-path fetch, flush=1
// ST_HALT  | core halted, everything frozen until reset
module branch_flow_ctrl #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst_n,
  branch_flow_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_B    = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_HLT  = 2'b11;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        nvz_q;
  logic              flush_q;
  logic              halted_q;

  logic              active;
  logic              is_br;
  logic              cond_true;
  logic              br_active;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] b_target;
  logic [ADDR_W-1:0] br_target;

  // Conditions use the registered flags, never the same-cycle ALU result.
  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'b000:  cond_true = ~nvz_q[0];
      3'b001:  cond_true = nvz_q[0];
      3'b010:  cond_true = ~nvz_q[0] & ~nvz_q[2];
      3'b011:  cond_true = nvz_q[2];
      3'b100:  cond_true = ~nvz_q[2];
      3'b101:  cond_true = nvz_q[2] | nvz_q[0];
      3'b110:  cond_true = nvz_q[1];
      default: cond_true = 1'b1;
    endcase
  end

  assign active    = bus.instr_valid & ~bus.stall & (state_q == ST_RUN);
  assign is_br     = (bus.br_op == OP_B) | (bus.br_op == OP_BR);
  assign br_active = active & is_br;
  assign pc_inc    = pc_q + PC_STEP;
  assign off_ext   = {{(ADDR_W-9){bus.br_off[8]}}, bus.br_off};
  assign b_target  = pc_inc + (off_ext << 1);
  assign br_target = bus.br_tgt & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      nvz_q    <= 3'b000;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (!bus.stall) begin
      case (state_q)
        ST_RUN: begin
          if (bus.instr_valid) begin
            case (bus.br_op)
              OP_NONE: begin
                pc_q  <= pc_inc;
                nvz_q <= (nvz_q & ~bus.flag_we) | (bus.alu_nvz & bus.flag_we);
              end
              OP_B, OP_BR: begin
                if (cond_true) begin
                  pc_q    <= (bus.br_op == OP_B) ? b_target : br_target;
                  state_q <= ST_FLUSH;
                  flush_q <= 1'b1;
                end else begin
                  pc_q <= pc_inc;
                end
              end
              OP_HLT: begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_FLUSH: begin
          pc_q    <= pc_inc;
          state_q <= ST_RUN;
          flush_q <= 1'b0;
        end
        ST_HALT: ;
        default: begin
          state_q  <= ST_RUN;
          flush_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc     = pc_q;
  assign bus.nvz    = nvz_q;
  assign bus.flush  = flush_q;
  assign bus.halted = halted_q;
  assign bus.taken  = br_active & cond_true;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] nt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= 16'h0000;
      nt_cnt_q    <= 16'h0000;
    end else if (br_active) begin
      if (cond_true) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'h0001;
      end else begin
        if (nt_cnt_q != 16'hFFFF) nt_cnt_q <= nt_cnt_q + 16'h0001;
      end
    end
  end

  assign bus.br_taken_cnt = taken_cnt_q;
  assign bus.br_nt_cnt    = nt_cnt_q;
`else
  assign bus.br_taken_cnt = 16'h0000;
  assign bus.br_nt_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Directed bench for branch_flow_ctrl: vector table plus hand sequences for flush stall, halt and reset.
module tb_branch_flow_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_flow_ctrl_if #(.ADDR_W(16)) bus ();

  branch_flow_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [1:0]  op;
    logic [2:0]  cond;
    logic [8:0]  off;
    logic [15:0] tgt;
    logic [2:0]  fwe;
    logic [2:0]  alu;
    logic        e_taken;
    logic [15:0] e_pc;
    logic        e_flush;
    logic [2:0]  e_nvz;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic st, logic v, logic [1:0] op, logic [2:0] c,
                              logic [8:0] off, logic [15:0] tgt, logic [2:0] fwe,
                              logic [2:0] alu, logic et, logic [15:0] epc,
                              logic ef, logic [2:0] en);
    vec_t r;
    r.stall = st; r.valid = v; r.op = op; r.cond = c; r.off = off; r.tgt = tgt;
    r.fwe = fwe; r.alu = alu; r.e_taken = et; r.e_pc = epc; r.e_flush = ef; r.e_nvz = en;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic st, logic v, logic [1:0] op, logic [2:0] c,
                       logic [8:0] off, logic [15:0] tgt, logic [2:0] fwe, logic [2:0] alu);
    bus.stall = st; bus.instr_valid = v; bus.br_op = op; bus.cond = c;
    bus.br_off = off; bus.br_tgt = tgt; bus.flag_we = fwe; bus.alu_nvz = alu;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_tc;
  logic [15:0] exp_nc;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();

    // stall valid op cond off tgt fwe alu | taken pc flush nvz
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h0002,0,3'b000));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h0004,0,3'b000));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h0006,0,3'b000));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h0008,0,3'b000));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h000A,0,3'b000));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h000C,0,3'b000));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h000E,0,3'b000));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b111,3'b001, 0,16'h0010,0,3'b001));
    vt.push_back(mk(0,1,2'b01,3'b001,9'h1FE,16'h0000,3'b000,3'b000, 1,16'h000E,1,3'b001));
    vt.push_back(mk(0,1,2'b01,3'b111,9'h040,16'h0000,3'b111,3'b110, 0,16'h0010,0,3'b001));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b111,3'b100, 0,16'h0012,0,3'b100));
    vt.push_back(mk(0,1,2'b01,3'b010,9'h010,16'h0000,3'b111,3'b000, 0,16'h0014,0,3'b100));
    vt.push_back(mk(0,1,2'b10,3'b011,9'h000,16'h1235,3'b000,3'b000, 1,16'h1234,1,3'b100));
    vt.push_back(mk(0,0,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h1236,0,3'b100));
    vt.push_back(mk(1,1,2'b10,3'b111,9'h000,16'h0000,3'b000,3'b000, 0,16'h1236,0,3'b100));
    vt.push_back(mk(1,1,2'b00,3'b000,9'h000,16'h0000,3'b111,3'b011, 0,16'h1236,0,3'b100));
    vt.push_back(mk(0,0,2'b01,3'b111,9'h000,16'h0000,3'b000,3'b000, 0,16'h1236,0,3'b100));
    vt.push_back(mk(0,1,2'b01,3'b000,9'h000,16'h0000,3'b000,3'b000, 1,16'h1238,1,3'b100));
    vt.push_back(mk(0,0,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h123A,0,3'b100));
    vt.push_back(mk(0,1,2'b01,3'b110,9'h005,16'h0000,3'b000,3'b000, 0,16'h123C,0,3'b100));
    vt.push_back(mk(0,1,2'b01,3'b101,9'h1FF,16'h0000,3'b000,3'b000, 1,16'h123C,1,3'b100));
    vt.push_back(mk(0,0,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'h123E,0,3'b100));
    vt.push_back(mk(0,1,2'b01,3'b100,9'h000,16'h0000,3'b000,3'b000, 0,16'h1240,0,3'b100));
    vt.push_back(mk(0,1,2'b00,3'b000,9'h000,16'h0000,3'b010,3'b111, 0,16'h1242,0,3'b110));
    vt.push_back(mk(0,1,2'b10,3'b111,9'h000,16'hFFFC,3'b000,3'b000, 1,16'hFFFC,1,3'b110));
    vt.push_back(mk(0,0,2'b00,3'b000,9'h000,16'h0000,3'b000,3'b000, 0,16'hFFFE,0,3'b110));
    vt.push_back(mk(0,1,2'b01,3'b111,9'h002,16'h0000,3'b000,3'b000, 1,16'h0004,1,3'b110));

    repeat (2) @(posedge clk);
    #3;
    chk("reset_pc", bus.pc, 16'h0000);
    chk("reset_nvz", bus.nvz, 3'b000);
    chk("reset_flush", bus.flush, 1'b0);
    chk("reset_halted", bus.halted, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].stall, vt[i].valid, vt[i].op, vt[i].cond, vt[i].off, vt[i].tgt,
            vt[i].fwe, vt[i].alu);
      #1;
      chk($sformatf("v%0d_taken", i), bus.taken, vt[i].e_taken);
      tick();
      chk($sformatf("v%0d_pc", i), bus.pc, vt[i].e_pc);
      chk($sformatf("v%0d_flush", i), bus.flush, vt[i].e_flush);
      chk($sformatf("v%0d_nvz", i), bus.nvz, vt[i].e_nvz);
      chk($sformatf("v%0d_halted", i), bus.halted, 1'b0);
    end

    // stall held two cycles while in FLUSH
    drive(1'b1, 1'b1, 2'b01, 3'b111, 9'h010, 16'h0000, 3'b111, 3'b111);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("fstall%0d_flush", k), bus.flush, 1'b1);
      chk($sformatf("fstall%0d_pc", k), bus.pc, 16'h0004);
    end
    idle();
    tick();
    chk("frel_flush", bus.flush, 1'b0);
    chk("frel_pc", bus.pc, 16'h0006);

`ifdef BRANCH_STATS_EN
    exp_tc = 16'd6;
    exp_nc = 16'd3;
`else
    exp_tc = 16'd0;
    exp_nc = 16'd0;
`endif
    chk("taken_cnt", bus.br_taken_cnt, exp_tc);
    chk("nt_cnt", bus.br_nt_cnt, exp_nc);

    // halt, then hammer with taken branches
    drive(1'b0, 1'b1, 2'b11, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
    tick();
    chk("hlt_halted", bus.halted, 1'b1);
    chk("hlt_pc", bus.pc, 16'h0006);
    drive(1'b0, 1'b1, 2'b01, 3'b111, 9'h010, 16'h0000, 3'b111, 3'b111);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("hold%0d_taken", k), bus.taken, 1'b0);
      tick();
      chk($sformatf("hold%0d_pc", k), bus.pc, 16'h0006);
      chk($sformatf("hold%0d_halted", k), bus.halted, 1'b1);
    end
    chk("hold_nvz", bus.nvz, 3'b110);
    chk("hold_taken_cnt", bus.br_taken_cnt, exp_tc);

    // asynchronous reset mid-HALT
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 16'h0000);
    chk("arst_halted", bus.halted, 1'b0);
    chk("arst_nvz", bus.nvz, 3'b000);
    chk("arst_taken_cnt", bus.br_taken_cnt, 16'h0000);
    chk("arst_nt_cnt", bus.br_nt_cnt, 16'h0000);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(1'b0, 1'b1, 2'b00, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000);
    tick();
    chk("post_halt_pc", bus.pc, 16'h0002);

    // reset mid-FLUSH must drop flush and resume in RUN
    drive(1'b0, 1'b1, 2'b10, 3'b111, 9'h000, 16'h0100, 3'b000, 3'b000);
    tick();
    chk("pre_rst_flush", bus.flush, 1'b1);
    chk("pre_rst_pc", bus.pc, 16'h0100);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("frst_flush", bus.flush, 1'b0);
    chk("frst_pc", bus.pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 2'b01, 3'b111, 9'h003, 16'h0000, 3'b000, 3'b000);
    #1;
    chk("frst_run_taken", bus.taken, 1'b1);
    tick();
    chk("frst_run_pc", bus.pc, 16'h0008);
    chk("frst_run_flush", bus.flush, 1'b1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
